// File: rtl/encode_32to5_scan.sv
// encode_32to5_scan
// Sequential 32-to-5 encoder: captures a multi-hot request vector and
// serialises it into 5-bit indices, one per accepted handshake, in priority
// order (inverse of the 5-to-32 one-hot decoder).
//
// Parameters:
//   PRIORITY_HIGH - 0: lowest set index first, 1: highest set index first
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   en       in   global enable; 0 freezes all state
//   load     in   capture request, honoured only in IDLE
//   x        in   [31:0] request vector captured on load
//   busy     out  high while scanning
//   y        out  [4:0] index of the current priority bit of pending
//   y_valid  out  y holds a valid index
//   y_ready  in   consumer accepts y
//   count    out  [5:0] indices emitted since the last load (0..32)
//   done     out  one-cycle pulse after the final index is accepted
//   none     out  one-cycle pulse when the loaded vector was all-zero
module encode_32to5_scan #(
    parameter bit PRIORITY_HIGH = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] x,
    output logic        busy,
    output logic [4:0]  y,
    output logic        y_valid,
    input  logic        y_ready,
    output logic [5:0]  count,
    output logic        done,
    output logic        none
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pending;
    logic [31:0] pick;
    logic [31:0] remaining;
    logic        handshake;

    // Priority encode of the pending register. The loop direction is chosen
    // so that the last match written wins: scanning upward keeps the highest
    // set bit, scanning downward keeps the lowest. pending is zero outside
    // SCAN, so y naturally reads 0 there.
    always_comb begin
        y = 5'd0;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < 32; i++) begin
                if (pending[i]) begin
                    y = 5'(i);
                end
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                if (pending[i]) begin
                    y = 5'(i);
                end
            end
        end
    end

    // The bit being emitted and what is left once it is accepted; an empty
    // remainder means this handshake retires the final index.
    assign pick      = 32'd1 << y;
    assign remaining = pending & ~pick;

    assign busy      = (state == SCAN);
    assign y_valid   = (state == SCAN) && en;
    assign handshake = y_valid && y_ready;

    // Control and datapath registers. The done/none pulses are cleared every
    // cycle regardless of en so that they always last exactly one clock; all
    // other state holds while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= 32'd0;
            count   <= 6'd0;
            done    <= 1'b0;
            none    <= 1'b0;
        end else begin
            done <= 1'b0;
            none <= 1'b0;
            if (en) begin
                case (state)
                    IDLE: begin
                        if (load) begin
                            pending <= x;
                            count   <= 6'd0;
                            if (x == 32'd0) begin
                                none <= 1'b1;
                            end else begin
                                state <= SCAN;
                            end
                        end
                    end
                    SCAN: begin
                        if (handshake) begin
                            pending <= remaining;
                            count   <= count + 6'd1;
                            if (remaining == 32'd0) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
